layer_seq: RTL and testbench

//  Sequences a multi-layer pass through the conv/fc engine with no host

---
 rtl/layer_seq_if.sv | 37 +++
 rtl/layer_seq.sv | 164 ++++++++++++++++
 tb/tb_layer_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/layer_seq_if.sv
// Host/engine bus for layer_seq: descriptor writes, sequence control,
// and the per-layer shape/config fields presented to the conv/fc engine.
interface layer_seq_if #(
   parameter int LAW = 3
) ();
   logic           cfg_we;
   logic [LAW+1:0] cfg_a;
   logic [31:0]    cfg_d;
   logic [LAW:0]   n_layers;
   logic           start;
   logic           abort;
   logic           layer_done;

   logic           run;
   logic           backprop;
   logic           enbias;
   logic [11:0]    ss, ds;
   logic [3:0]     dd, id, od;
   logic [9:0]     is, os, fs, ks;
   logic [4:0]     ih, iw, oh, ow, kh, kw;
   logic           busy;
   logic           seq_done;
   logic           err;
   logic [LAW-1:0] cur_layer;

   modport master (
      output cfg_we, cfg_a, cfg_d, n_layers, start, abort, layer_done,
      input  run, backprop, enbias, ss, ds, dd, id, od, is, os, fs, ks,
             ih, iw, oh, ow, kh, kw, busy, seq_done, err, cur_layer
   );

   modport slave (
      input  cfg_we, cfg_a, cfg_d, n_layers, start, abort, layer_done,
      output run, backprop, enbias, ss, ds, dd, id, od, is, os, fs, ks,
             ih, iw, oh, ow, kh, kw, busy, seq_done, err, cur_layer
   );
endinterface

// File: rtl/layer_seq.sv
// Walks a preloaded descriptor table and runs the engine one layer at a time,
// with a run-low gap between layers and a per-layer timeout.
module layer_seq #(
   parameter int MAX_LAYERS = 8,
   parameter int LAW        = 3,
   parameter int GAP_CYC    = 4,
   parameter int TO_W       = 20
) (
   input logic        clk,
   input logic        rst,
   layer_seq_if.slave bus
);
   localparam int            GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
   localparam logic [LAW:0]  MAXL     = (LAW+1)'(MAX_LAYERS);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SETUP, S_RUN, S_GAP, S_FIN
   } state_t;

   state_t         state_q, state_d;
   logic [LAW-1:0] cur_q, cur_d;
   logic [LAW:0]   n_q, n_d;
   logic           err_q, err_d;
   logic [TO_W-1:0] to_q, to_d;
   logic [GW-1:0]  gap_q, gap_d;
   logic           last_layer;

   // Word memories keep only the bits each descriptor word actually carries.
   logic [31:0] m0 [MAX_LAYERS];
   logic [31:0] m1 [MAX_LAYERS];
   logic [29:0] m2 [MAX_LAYERS];
   logic [13:0] m3 [MAX_LAYERS];
   logic [31:0] w0_q, w1_q;
   logic [29:0] w2_q;
   logic [13:0] w3_q;

   always_ff @(posedge clk) begin
      if (bus.cfg_we && state_q == S_IDLE) begin
         case (bus.cfg_a[1:0])
            2'd0:    m0[bus.cfg_a[LAW+1:2]] <= bus.cfg_d;
            2'd1:    m1[bus.cfg_a[LAW+1:2]] <= bus.cfg_d;
            2'd2:    m2[bus.cfg_a[LAW+1:2]] <= bus.cfg_d[29:0];
            default: m3[bus.cfg_a[LAW+1:2]] <= bus.cfg_d[13:0];
         endcase
      end
   end

   // Synchronous table read lands directly in the config registers, so the
   // fields are valid throughout SETUP, one cycle ahead of run.
   always_ff @(posedge clk) begin
      if (rst) begin
         w0_q <= '0;
         w1_q <= '0;
         w2_q <= '0;
         w3_q <= '0;
      end else if (state_q == S_LOAD) begin
         w0_q <= m0[cur_q];
         w1_q <= m1[cur_q];
         w2_q <= m2[cur_q];
         w3_q <= m3[cur_q];
      end
   end

   assign last_layer = ({1'b0, cur_q} == (n_q - 1'b1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         n_q     <= '0;
         err_q   <= 1'b0;
         to_q    <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         n_q     <= n_d;
         err_q   <= err_d;
         to_q    <= to_d;
         gap_q   <= gap_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      n_d     = n_q;
      err_d   = err_q;
      to_d    = to_q;
      gap_d   = gap_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.n_layers > MAXL) begin
                  err_d = 1'b1;
               end else begin
                  err_d = 1'b0;
                  n_d   = bus.n_layers;
                  cur_d = '0;
                  state_d = (bus.n_layers == '0) ? S_FIN : S_LOAD;
               end
            end
         end
         S_LOAD:  state_d = S_SETUP;
         S_SETUP: begin
            state_d = S_RUN;
            to_d    = '0;
         end
         S_RUN: begin
            if (bus.layer_done) begin
               gap_d   = '0;
               state_d = last_layer ? S_FIN : S_GAP;
            end else if (&to_q) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               to_d = to_q + 1'b1;
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) begin
               cur_d   = cur_q + 1'b1;
               state_d = S_LOAD;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Abort wins over everything, including a same-cycle layer_done or timeout.
      if (bus.abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         cur_d   = cur_q;
         err_d   = err_q;
      end
   end

   assign bus.run       = (state_q == S_RUN);
   assign bus.busy      = (state_q == S_LOAD) || (state_q == S_SETUP) ||
                          (state_q == S_RUN)  || (state_q == S_GAP);
   assign bus.seq_done  = (state_q == S_FIN);
   assign bus.err       = err_q;
   assign bus.cur_layer = cur_q;

   assign bus.ss       = w0_q[11:0];
   assign bus.ds       = w0_q[23:12];
   assign bus.dd       = w0_q[27:24];
   assign bus.id       = w0_q[31:28];
   assign bus.is       = w1_q[9:0];
   assign bus.os       = w1_q[19:10];
   assign bus.fs       = w1_q[29:20];
   assign bus.backprop = w1_q[30];
   assign bus.enbias   = w1_q[31];
   assign bus.ks       = w2_q[9:0];
   assign bus.ih       = w2_q[14:10];
   assign bus.iw       = w2_q[19:15];
   assign bus.oh       = w2_q[24:20];
   assign bus.ow       = w2_q[29:25];
   assign bus.kh       = w3_q[4:0];
   assign bus.kw       = w3_q[9:5];
   assign bus.od       = w3_q[13:10];
endmodule

// File: tb/tb_layer_seq.sv
// Directed bench for layer_seq: multi-layer run, empty/over-range sequences,
// abort, timeout, writes/start while busy, reset in the gap.
module tb_layer_seq;
   localparam int GAP = 4;

   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   layer_seq_if #(.LAW(3)) bus ();

   layer_seq #(
      .MAX_LAYERS(8),
      .LAW       (3),
      .GAP_CYC   (GAP),
      .TO_W      (4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int layer, input int word, input logic [31:0] d);
      bus.cfg_we = 1'b1;
      bus.cfg_a  = 5'((layer << 2) | word);
      bus.cfg_d  = d;
      tick();
      bus.cfg_we = 1'b0;
   endtask

   task automatic go(input int n);
      bus.n_layers = 4'(n);
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
   endtask

   task automatic wait_run(output int c);
      c = 0;
      while (bus.run !== 1'b1 && c < 30) begin
         tick();
         c++;
      end
   endtask

   task automatic done_pulse();
      bus.layer_done = 1'b1;
      tick();
      bus.layer_done = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total++; if (bus.run !== 1'b0) begin bad++; $display("FAIL rst_run got=%0d want=0", bus.run); end
      total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d want=0", bus.busy); end
      total++; if (bus.seq_done !== 1'b0) begin bad++; $display("FAIL rst_seq_done got=%0d want=0", bus.seq_done); end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0d want=0", bus.err); end
      total++; if (bus.cur_layer !== 3'd0) begin bad++; $display("FAIL rst_cur got=%0d want=0", bus.cur_layer); end
      total++; if (bus.ss !== 12'd0 || bus.od !== 4'd0) begin bad++; $display("FAIL rst_cfg got=%0d/%0d want=0/0", bus.ss, bus.od); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_two_layers();
      int c;
      // Layer 0: ss=784 ds=10 dd=1 id=2 | is=5 os=6 fs=7 bp=1 eb=0 | ks=9 ih=1 iw=2 oh=3 ow=4 | kh=3 kw=3 od=15 (junk in unused bits)
      wr(0, 0, {4'd2, 4'd1, 12'd10, 12'd784});
      wr(0, 1, {1'b0, 1'b1, 10'd7, 10'd6, 10'd5});
      wr(0, 2, {2'b11, 5'd4, 5'd3, 5'd2, 5'd1, 10'd9});
      wr(0, 3, {18'h3ffff, 4'd15, 5'd3, 5'd3});
      wr(1, 0, {4'd0, 4'd0, 12'd20, 12'd100});
      wr(1, 1, {1'b1, 1'b0, 30'd0});
      wr(1, 2, 32'd0);
      wr(1, 3, {18'd0, 4'd2, 5'd1, 5'd1});
      wr(2, 0, {4'd0, 4'd0, 12'd0, 12'd300});
      go(2);
      total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL t1_busy_load got=%0d want=1", bus.busy); end
      tick();
      total++; if (bus.run !== 1'b0 || bus.ss !== 12'd784) begin bad++; $display("FAIL t1_setup run/ss got=%0d/%0d want=0/784", bus.run, bus.ss); end
      tick();
      total++; if (bus.run !== 1'b1) begin bad++; $display("FAIL t1_run0_latency got=%0d want=1", bus.run); end
      total++; if (bus.ds !== 12'd10 || bus.dd !== 4'd1 || bus.id !== 4'd2) begin bad++; $display("FAIL t1_w0 ds/dd/id got=%0d/%0d/%0d want=10/1/2", bus.ds, bus.dd, bus.id); end
      total++; if (bus.is !== 10'd5 || bus.os !== 10'd6 || bus.fs !== 10'd7) begin bad++; $display("FAIL t1_w1 is/os/fs got=%0d/%0d/%0d want=5/6/7", bus.is, bus.os, bus.fs); end
      total++; if (bus.backprop !== 1'b1 || bus.enbias !== 1'b0) begin bad++; $display("FAIL t1_mode bp/eb got=%0d/%0d want=1/0", bus.backprop, bus.enbias); end
      total++; if (bus.ks !== 10'd9 || bus.ih !== 5'd1 || bus.iw !== 5'd2 || bus.oh !== 5'd3 || bus.ow !== 5'd4) begin bad++; $display("FAIL t1_w2 ks/ih/iw/oh/ow got=%0d/%0d/%0d/%0d/%0d want=9/1/2/3/4", bus.ks, bus.ih, bus.iw, bus.oh, bus.ow); end
      total++; if (bus.kh !== 5'd3 || bus.kw !== 5'd3 || bus.od !== 4'd15) begin bad++; $display("FAIL t1_w3 kh/kw/od got=%0d/%0d/%0d want=3/3/15", bus.kh, bus.kw, bus.od); end
      repeat (10) tick();
      done_pulse();
      total++; if (bus.run !== 1'b0 || bus.busy !== 1'b1) begin bad++; $display("FAIL t1_done0 run/busy got=%0d/%0d want=0/1", bus.run, bus.busy); end
      wait_run(c);
      total++; if (c !== GAP + 2) begin bad++; $display("FAIL t1_low_cycles got=%0d want=%0d", c, GAP + 2); end
      total++; if (bus.ss !== 12'd100 || bus.od !== 4'd2 || bus.enbias !== 1'b1 || bus.backprop !== 1'b0) begin bad++; $display("FAIL t1_l1_cfg ss/od/eb/bp got=%0d/%0d/%0d/%0d want=100/2/1/0", bus.ss, bus.od, bus.enbias, bus.backprop); end
      total++; if (bus.cur_layer !== 3'd1) begin bad++; $display("FAIL t1_cur1 got=%0d want=1", bus.cur_layer); end
      repeat (10) tick();
      done_pulse();
      total++; if (bus.seq_done !== 1'b1 || bus.busy !== 1'b0 || bus.run !== 1'b0) begin bad++; $display("FAIL t1_fin seq/busy/run got=%0d/%0d/%0d want=1/0/0", bus.seq_done, bus.busy, bus.run); end
      tick();
      total++; if (bus.seq_done !== 1'b0 || bus.ss !== 12'd100) begin bad++; $display("FAIL t1_after seq/ss got=%0d/%0d want=0/100", bus.seq_done, bus.ss); end
   endtask

   task automatic test_zero_over();
      go(0);
      total++; if (bus.seq_done !== 1'b1 || bus.run !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL t2_zero seq/run/busy got=%0d/%0d/%0d want=1/0/0", bus.seq_done, bus.run, bus.busy); end
      tick();
      total++; if (bus.seq_done !== 1'b0 || bus.run !== 1'b0) begin bad++; $display("FAIL t2_zero_after seq/run got=%0d/%0d want=0/0", bus.seq_done, bus.run); end
      go(9);
      tick();
      total++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.run !== 1'b0) begin bad++; $display("FAIL t2_over err/busy/run got=%0d/%0d/%0d want=1/0/0", bus.err, bus.busy, bus.run); end
      go(0);
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL t2_err_clear got=%0d want=0", bus.err); end
      tick();
   endtask

   task automatic test_abort();
      int c;
      int seen;
      go(3);
      wait_run(c);
      repeat (2) tick();
      done_pulse();
      wait_run(c);
      total++; if (c !== GAP + 2 || bus.cur_layer !== 3'd1) begin bad++; $display("FAIL t3_second_run gap/cur got=%0d/%0d want=%0d/1", c, bus.cur_layer, GAP + 2); end
      repeat (2) tick();
      bus.abort = 1'b1;
      bus.layer_done = 1'b1;
      tick();
      bus.abort = 1'b0;
      bus.layer_done = 1'b0;
      total++; if (bus.run !== 1'b0 || bus.busy !== 1'b0 || bus.seq_done !== 1'b0) begin bad++; $display("FAIL t3_abort run/busy/seq got=%0d/%0d/%0d want=0/0/0", bus.run, bus.busy, bus.seq_done); end
      total++; if (bus.cur_layer !== 3'd1) begin bad++; $display("FAIL t3_abort_cur got=%0d want=1", bus.cur_layer); end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.seq_done === 1'b1 || bus.run === 1'b1) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL t3_quiet got=%0d want=0", seen); end
   endtask

   task automatic test_timeout();
      int c;
      go(1);
      wait_run(c);
      total++; if (c !== 2) begin bad++; $display("FAIL t4_latency got=%0d want=2", c); end
      c = 0;
      while (bus.run === 1'b1 && c < 40) begin
         c++;
         tick();
      end
      total++; if (c !== 16) begin bad++; $display("FAIL t4_run_cycles got=%0d want=16", c); end
      total++; if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.seq_done !== 1'b0) begin bad++; $display("FAIL t4_to err/busy/seq got=%0d/%0d/%0d want=1/0/0", bus.err, bus.busy, bus.seq_done); end
      tick();
   endtask

   task automatic test_busy_write();
      int c;
      go(1);
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL t5_err_clear got=%0d want=0", bus.err); end
      wait_run(c);
      wr(0, 0, {4'd0, 4'd0, 12'd0, 12'd55});
      go(2);
      total++; if (bus.run !== 1'b1 || bus.cur_layer !== 3'd0) begin bad++; $display("FAIL t5_no_restart run/cur got=%0d/%0d want=1/0", bus.run, bus.cur_layer); end
      repeat (3) tick();
      done_pulse();
      total++; if (bus.seq_done !== 1'b1) begin bad++; $display("FAIL t5_fin1 got=%0d want=1", bus.seq_done); end
      tick();
      go(1);
      wait_run(c);
      total++; if (bus.ss !== 12'd784) begin bad++; $display("FAIL t5_old_ss got=%0d want=784", bus.ss); end
      repeat (2) tick();
      done_pulse();
      total++; if (bus.seq_done !== 1'b1) begin bad++; $display("FAIL t5_fin2 got=%0d want=1", bus.seq_done); end
      tick();
   endtask

   task automatic test_rst_gap();
      int c;
      go(2);
      wait_run(c);
      repeat (2) tick();
      done_pulse();
      tick();
      rst = 1'b1;
      tick();
      total++; if (bus.run !== 1'b0 || bus.busy !== 1'b0 || bus.seq_done !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL t6_rst ctl run/busy/seq/err got=%0d/%0d/%0d/%0d want=0/0/0/0", bus.run, bus.busy, bus.seq_done, bus.err); end
      total++; if (bus.cur_layer !== 3'd0 || bus.ss !== 12'd0 || bus.od !== 4'd0 || bus.backprop !== 1'b0) begin bad++; $display("FAIL t6_rst cfg cur/ss/od/bp got=%0d/%0d/%0d/%0d want=0/0/0/0", bus.cur_layer, bus.ss, bus.od, bus.backprop); end
      rst = 1'b0;
      tick();
      go(2);
      wait_run(c);
      total++; if (c !== 2 || bus.cur_layer !== 3'd0 || bus.ss !== 12'd784) begin bad++; $display("FAIL t6_restart lat/cur/ss got=%0d/%0d/%0d want=2/0/784", c, bus.cur_layer, bus.ss); end
      repeat (2) tick();
      done_pulse();
      wait_run(c);
      total++; if (bus.cur_layer !== 3'd1 || bus.ss !== 12'd100) begin bad++; $display("FAIL t6_l1 cur/ss got=%0d/%0d want=1/100", bus.cur_layer, bus.ss); end
      repeat (2) tick();
      done_pulse();
      total++; if (bus.seq_done !== 1'b1) begin bad++; $display("FAIL t6_fin got=%0d want=1", bus.seq_done); end
      tick();
   endtask

   initial begin
      rst            = 1'b1;
      bus.cfg_we     = 1'b0;
      bus.cfg_a      = '0;
      bus.cfg_d      = '0;
      bus.n_layers   = '0;
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.layer_done = 1'b0;
      test_reset();
      test_two_layers();
      test_zero_over();
      test_abort();
      test_timeout();
      test_busy_write();
      test_rst_gap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
